// File: rtl/spi_master_burst_pkg.sv
// spi_master_burst_pkg: FSM states and SPI mode encodings shared by the burst master
package spi_master_burst_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_HOLD} state_t;
    // {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;
endpackage

// File: rtl/spi_master_burst_if.sv
// spi_master_burst_if: framer-side burst request, TX stream and RX stream
interface spi_master_burst_if #(parameter int DATA_W = 8, parameter int LEN_W = 6);
    logic              start;
    logic [LEN_W-1:0]  burst_len;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              busy;
    logic              done;
    modport master (output start, burst_len, tx_data, tx_valid, input tx_ready, rx_data, rx_valid, busy, done);
    modport slave (input start, burst_len, tx_data, tx_valid, output tx_ready, rx_data, rx_valid, busy, done);
endinterface

// File: rtl/spi_master_burst_clk_gen.sv
// spi_master_burst_clk_gen: SCLK half-period divider with leading/trailing edge strobes
module spi_master_burst_clk_gen #(
    parameter int CLK_DIV = 4,
    parameter bit CPOL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_sclk,
    output logic o_lead,
    output logic o_trail
);
    localparam int CW = $clog2(CLK_DIV + 1);
    logic [CW-1:0] r_cnt;
    logic          r_lvl;
    logic          w_tick;
    assign w_tick  = i_en && (r_cnt == CW'(CLK_DIV - 1));
    assign o_lead  = w_tick && !r_lvl;
    assign o_trail = w_tick && r_lvl;
    assign o_sclk  = r_lvl ^ CPOL;
    // Disabled means parked at idle level with a fresh count, so every word starts with a full half-period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_lvl <= 1'b0;
        end else if (!i_en) begin
            r_cnt <= '0;
            r_lvl <= 1'b0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            r_lvl <= r_lvl ^ w_tick;
        end
    end
endmodule

// File: rtl/spi_master_burst.sv
// spi_master_burst: full-duplex SPI master shifting multi-word bursts with cs held low and TX stall
module spi_master_burst
    import spi_master_burst_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter bit CPOL    = 1'b0,
    parameter bit CPHA    = 1'b0,
    parameter int LEN_W   = 6
) (
    input  logic clk,
    input  logic rst,
    spi_master_burst_if.slave bus,
    output logic o_sclk,
    output logic o_mosi,
    input  logic i_miso,
    output logic o_cs
);
    localparam int BW = $clog2(DATA_W);
    localparam int HW = $clog2(CLK_DIV + 1);
    state_t            r_state, w_next;
    logic [LEN_W-1:0]  r_words;
    logic [BW-1:0]     r_bit;
    logic [HW-1:0]     r_hold;
    logic [DATA_W-1:0] r_tx, r_rx_data, w_rx_next;
    logic [DATA_W-2:0] r_rx_sh;
    logic r_mosi, r_cs, r_rx_valid, r_done;
    logic w_lead, w_trail, w_accept, w_shift, w_sample, w_last_bit, w_word_end, w_hold_end;

    spi_master_burst_clk_gen #(.CLK_DIV(CLK_DIV), .CPOL(CPOL)) u_clk_gen (
        .clk     (clk),
        .rst     (rst),
        .i_en    (r_state == ST_SHIFT),
        .o_sclk  (o_sclk),
        .o_lead  (w_lead),
        .o_trail (w_trail)
    );

    assign w_accept   = (r_state == ST_LOAD) && bus.tx_valid;
    assign w_shift    = CPHA ? w_lead : w_trail;
    assign w_sample   = CPHA ? w_trail : w_lead;
    assign w_last_bit = r_bit == BW'(DATA_W - 1);
    assign w_word_end = w_trail && w_last_bit;
    assign w_hold_end = r_hold == HW'(CLK_DIV - 1);
    assign w_rx_next  = {r_rx_sh, i_miso};

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = bus.start ? ST_LOAD : ST_IDLE;
            ST_LOAD:  w_next = w_accept ? ST_SHIFT : ST_LOAD;
            ST_SHIFT: w_next = !w_word_end ? ST_SHIFT : (r_words == '0 ? ST_HOLD : ST_LOAD);
            default:  w_next = w_hold_end ? ST_IDLE : ST_HOLD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_words    <= '0;
            r_bit      <= '0;
            r_hold     <= '0;
            r_tx       <= '0;
            r_rx_sh    <= '0;
            r_rx_data  <= '0;
            r_mosi     <= 1'b0;
            r_cs       <= 1'b1;
            r_rx_valid <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_cs       <= (w_next == ST_IDLE) || (w_next == ST_HOLD);
            r_done     <= (r_state == ST_HOLD) && w_hold_end;
            r_rx_valid <= w_sample && w_last_bit;
            r_hold     <= (r_state == ST_HOLD) ? r_hold + 1'b1 : '0;
            if ((r_state == ST_IDLE) && bus.start)
                r_words <= bus.burst_len;
            else if (w_word_end && (r_words != '0))
                r_words <= r_words - 1'b1;
            if (w_trail)
                r_bit <= w_last_bit ? '0 : r_bit + 1'b1;
            // CPHA=0 presents the MSB at accept; CPHA=1 waits for the first leading edge
            if (w_accept) begin
                r_tx <= CPHA ? bus.tx_data : bus.tx_data << 1;
                if (!CPHA)
                    r_mosi <= bus.tx_data[DATA_W-1];
            end else if (w_shift) begin
                r_tx   <= r_tx << 1;
                r_mosi <= r_tx[DATA_W-1];
            end
            if (w_word_end && (r_words == '0))
                r_mosi <= 1'b0;
            if (w_sample)
                r_rx_sh <= w_rx_next[DATA_W-2:0];
            if (w_sample && w_last_bit)
                r_rx_data <= w_rx_next;
        end
    end

    assign bus.tx_ready = r_state == ST_LOAD;
    assign bus.busy     = r_state != ST_IDLE;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.done     = r_done;
    assign o_mosi       = r_mosi;
    assign o_cs         = r_cs;
endmodule

// File: tb/tb_spi_master_burst.sv
// tb_spi_master_burst: scoreboard bench for a mode-0 8-bit master and a mode-3 16-bit master
module tb_spi_master_burst;
    logic clk = 1'b0;
    logic rst = 1'b1;
    initial forever #5 clk = ~clk;

    spi_master_burst_if #(.DATA_W(8), .LEN_W(6)) a_if ();
    spi_master_burst_if #(.DATA_W(16), .LEN_W(5)) b_if ();
    logic a_sclk, a_mosi, a_miso, a_cs, a_loop;
    logic b_sclk, b_mosi, b_miso, b_cs;
    logic [7:0] a_sreg;
    assign a_miso = a_loop ? a_mosi : a_sreg[7];
    assign b_miso = b_mosi;

    spi_master_burst #(.DATA_W(8), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0), .LEN_W(6)) u_a (
        .clk(clk), .rst(rst), .bus(a_if), .o_sclk(a_sclk), .o_mosi(a_mosi), .i_miso(a_miso), .o_cs(a_cs));
    spi_master_burst #(.DATA_W(16), .CLK_DIV(3), .CPOL(1'b1), .CPHA(1'b1), .LEN_W(5)) u_b (
        .clk(clk), .rst(rst), .bus(b_if), .o_sclk(b_sclk), .o_mosi(b_mosi), .i_miso(b_miso), .o_cs(b_cs));

    int n_chk = 0;
    int n_pass = 0;
    logic [7:0]  a_exp_rx[$], a_exp_tx[$], a_slv[$];
    logic [15:0] b_exp_rx[$], b_exp_tx[$];
    int a_cs_low = 0, a_done_n = 0, b_done_n = 0, a_rise = 0, b_rise = 0, a_cs_rise = 0;
    logic a_mosi_q = 1'b0, b_mosi_q = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic chk_rst(input string nm, input logic [6:0] pins, input logic [6:0] exp_pins, input logic [63:0] rxd);
        chk({nm, "_pins"}, 64'(pins), 64'(exp_pins));
        chk({nm, "_rx_data"}, rxd, 64'd0);
    endtask

    // Output counters, mosi snapshots away from the sclk edge, and the RX scoreboards
    initial forever begin
        @(negedge clk);
        if (!a_cs) a_cs_low++;
        if (a_if.done) a_done_n++;
        if (b_if.done) b_done_n++;
        a_mosi_q = a_mosi;
        b_mosi_q = b_mosi;
        if (a_if.rx_valid) begin
            chk("a_rx_expected", 64'(a_exp_rx.size() != 0), 64'd1);
            if (a_exp_rx.size() != 0) chk("a_rx_data", 64'(a_if.rx_data), 64'(a_exp_rx.pop_front()));
        end
        if (b_if.rx_valid) begin
            chk("b_rx_expected", 64'(b_exp_rx.size() != 0), 64'd1);
            if (b_exp_rx.size() != 0) chk("b_rx_data", 64'(b_if.rx_data), 64'(b_exp_rx.pop_front()));
        end
    end

    initial forever begin
        @(posedge a_cs);
        a_cs_rise++;
    end

    // Both masters sample on sclk rising edge in their modes; rebuild the words seen on mosi
    initial begin : a_cap
        logic [7:0] sr;
        int nb;
        sr = '0;
        nb = 0;
        forever begin
            @(posedge a_sclk or posedge rst);
            if (rst) nb = 0;
            else begin
                a_rise++;
                sr = {sr[6:0], a_mosi_q};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    chk("a_mosi_expected", 64'(a_exp_tx.size() != 0), 64'd1);
                    if (a_exp_tx.size() != 0) chk("a_mosi_word", 64'(sr), 64'(a_exp_tx.pop_front()));
                end
            end
        end
    end

    initial begin : b_cap
        logic [15:0] sr;
        int nb;
        sr = '0;
        nb = 0;
        forever begin
            @(posedge b_sclk or posedge rst);
            if (rst) nb = 0;
            else begin
                b_rise++;
                sr = {sr[14:0], b_mosi_q};
                nb++;
                if (nb == 16) begin
                    nb = 0;
                    chk("b_mosi_expected", 64'(b_exp_tx.size() != 0), 64'd1);
                    if (b_exp_tx.size() != 0) chk("b_mosi_word", 64'(sr), 64'(b_exp_tx.pop_front()));
                end
            end
        end
    end

    // Mode-0 slave for instance A: MSB ready at cs fall, shifts on falling sclk, reloads after 8 bits
    initial begin : a_slave
        int nb;
        logic cs_p, sclk_p;
        a_sreg = 8'h00;
        nb = 0;
        cs_p = 1'b1;
        sclk_p = 1'b0;
        forever begin
            @(negedge a_cs or posedge a_sclk or negedge a_sclk);
            if (cs_p && !a_cs) begin
                a_sreg = (a_slv.size() != 0) ? a_slv.pop_front() : 8'h00;
                nb = 0;
            end else if (a_sclk && !sclk_p) nb++;
            else if (!a_sclk && sclk_p) begin
                if (nb == 8) begin
                    a_sreg = (a_slv.size() != 0) ? a_slv.pop_front() : 8'h00;
                    nb = 0;
                end else a_sreg = a_sreg << 1;
            end
            cs_p = a_cs;
            sclk_p = a_sclk;
        end
    end

    task automatic a_start(input logic [5:0] len);
        a_if.start = 1'b1;
        a_if.burst_len = len;
        @(negedge clk);
        a_if.start = 1'b0;
    endtask

    task automatic b_start(input logic [4:0] len);
        b_if.start = 1'b1;
        b_if.burst_len = len;
        @(negedge clk);
        b_if.start = 1'b0;
    endtask

    task automatic a_send(input logic [7:0] d, input logic [7:0] rx);
        int n = 0;
        a_exp_tx.push_back(d);
        a_exp_rx.push_back(rx);
        a_if.tx_data = d;
        a_if.tx_valid = 1'b1;
        while (!a_if.tx_ready && n < 200) begin @(negedge clk); n++; end
        if (n == 200) chk("a_tx_accept_timeout", 64'(a_if.tx_ready), 64'd1);
        @(negedge clk);
        a_if.tx_valid = 1'b0;
    endtask

    task automatic b_send(input logic [15:0] d);
        int n = 0;
        b_exp_tx.push_back(d);
        b_exp_rx.push_back(d);
        b_if.tx_data = d;
        b_if.tx_valid = 1'b1;
        while (!b_if.tx_ready && n < 300) begin @(negedge clk); n++; end
        if (n == 300) chk("b_tx_accept_timeout", 64'(b_if.tx_ready), 64'd1);
        @(negedge clk);
        b_if.tx_valid = 1'b0;
    endtask

    task automatic a_wait_done(input string nm);
        int n = 0;
        while (!a_if.done && n < 5000) begin @(negedge clk); n++; end
        chk(nm, 64'(a_if.done), 64'd1);
        @(negedge clk);
    endtask

    task automatic b_wait_done(input string nm);
        int n = 0;
        while (!b_if.done && n < 5000) begin @(negedge clk); n++; end
        chk(nm, 64'(b_if.done), 64'd1);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within 2000000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, d0, c0, bad;
        logic [335:0] pkt;
        a_if.start = 1'b0; a_if.burst_len = '0; a_if.tx_data = '0; a_if.tx_valid = 1'b0;
        b_if.start = 1'b0; b_if.burst_len = '0; b_if.tx_data = '0; b_if.tx_valid = 1'b0;
        a_loop = 1'b1;
        repeat (3) @(negedge clk);
        chk_rst("a_reset_init", {a_sclk, a_cs, a_mosi, a_if.tx_ready, a_if.rx_valid, a_if.busy, a_if.done}, 7'b0100000, 64'(a_if.rx_data));
        chk_rst("b_reset_init", {b_sclk, b_cs, b_mosi, b_if.tx_ready, b_if.rx_valid, b_if.busy, b_if.done}, 7'b1100000, 64'(b_if.rx_data));
        rst = 1'b0;
        @(negedge clk);

        // Single 8'hA5 word in loopback: LOAD cycle plus 16 half-periods of 2 clocks keep cs low 33 cycles
        a_cs_low = 0; d0 = a_done_n; r0 = a_rise;
        a_start(6'd0);
        chk("t2_busy", 64'(a_if.busy), 64'd1);
        a_send(8'hA5, 8'hA5);
        a_wait_done("t2_done_seen");
        chk("t2_cs_low_cycles", 64'(a_cs_low), 64'd33);
        chk("t2_done_count", 64'(a_done_n - d0), 64'd1);
        chk("t2_sclk_rises", 64'(a_rise - r0), 64'd8);
        chk("t2_rx_data_held", 64'(a_if.rx_data), 64'hA5);
        chk("t2_idle_pins", 64'({a_cs, a_sclk, a_mosi, a_if.busy}), 64'b1000);

        // Reset pulse while idle clears the held RX word immediately
        #2 rst = 1'b1;
        #1 chk_rst("t1_idle_reset", {a_sclk, a_cs, a_mosi, a_if.tx_ready, a_if.rx_valid, a_if.busy, a_if.done}, 7'b0100000, 64'(a_if.rx_data));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Three-word burst against a slave returning 3C, FF, 01
        a_loop = 1'b0;
        a_slv.push_back(8'h3C); a_slv.push_back(8'hFF); a_slv.push_back(8'h01);
        d0 = a_done_n; r0 = a_rise; c0 = a_cs_rise;
        a_start(6'd2);
        a_send(8'h28, 8'h3C);
        a_send(8'h00, 8'hFF);
        a_send(8'h81, 8'h01);
        a_wait_done("t3_done_seen");
        chk("t3_sclk_rises", 64'(a_rise - r0), 64'd24);
        chk("t3_cs_rises", 64'(a_cs_rise - c0), 64'd1);
        chk("t3_done_count", 64'(a_done_n - d0), 64'd1);

        // TX stall of 10 cycles before word 2: sclk parked low, cs low, ready held
        a_loop = 1'b1;
        d0 = a_done_n; r0 = a_rise;
        a_start(6'd1);
        a_send(8'h96, 8'h96);
        bad = 0;
        while (!a_if.tx_ready && bad < 200) begin @(negedge clk); bad++; end
        chk("t4_reach_load", 64'(a_if.tx_ready), 64'd1);
        bad = 0;
        repeat (10) begin
            if (a_sclk || a_cs || !a_if.tx_ready) bad++;
            @(negedge clk);
        end
        chk("t4_stall_cycles_bad", 64'(bad), 64'd0);
        a_send(8'h3B, 8'h3B);
        a_wait_done("t4_done_seen");
        chk("t4_sclk_rises", 64'(a_rise - r0), 64'd16);
        chk("t4_done_count", 64'(a_done_n - d0), 64'd1);

        // Reset mid-word aborts with no done or RX pulse, then a fresh burst works
        d0 = a_done_n;
        a_start(6'd0);
        a_if.tx_data = 8'hE7;
        a_if.tx_valid = 1'b1;
        @(negedge clk);
        a_if.tx_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("t1_mid_word_busy", 64'(a_if.busy), 64'd1);
        #2 rst = 1'b1;
        #1 chk_rst("t1_word_reset", {a_sclk, a_cs, a_mosi, a_if.tx_ready, a_if.rx_valid, a_if.busy, a_if.done}, 7'b0100000, 64'(a_if.rx_data));
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("t1_abort_no_done", 64'(a_done_n - d0), 64'd0);
        r0 = a_rise;
        a_start(6'd0);
        a_send(8'h5A, 8'h5A);
        a_wait_done("t1_after_reset_done");
        chk("t1_after_reset_rises", 64'(a_rise - r0), 64'd8);

        // Mode 3 instance: sclk idles high, single word loopback
        chk("t5_sclk_idle_high", 64'(b_sclk), 64'd1);
        d0 = b_done_n; r0 = b_rise;
        b_start(5'd0);
        b_send(16'h00C3);
        b_wait_done("t5_done_seen");
        chk("t5_rx_data", 64'(b_if.rx_data), 64'h00C3);
        chk("t5_sclk_rises", 64'(b_rise - r0), 64'd16);
        chk("t5_sclk_idle_after", 64'({b_sclk, b_cs}), 64'b11);

        // 21-word packet, MSB-first, zero padded to 336 bits
        pkt = {8'h28, 64'd129, "here is data", 168'd0};
        d0 = b_done_n; r0 = b_rise;
        b_start(5'd20);
        for (int i = 0; i < 21; i++) b_send(pkt[335 - 16 * i -: 16]);
        b_wait_done("t6_done_seen");
        chk("t6_sclk_rises", 64'(b_rise - r0), 64'd336);
        chk("t6_done_count", 64'(b_done_n - d0), 64'd1);

        repeat (4) @(negedge clk);
        chk("end_a_rx_queue_empty", 64'(a_exp_rx.size()), 64'd0);
        chk("end_a_tx_queue_empty", 64'(a_exp_tx.size()), 64'd0);
        chk("end_b_rx_queue_empty", 64'(b_exp_rx.size()), 64'd0);
        chk("end_b_tx_queue_empty", 64'(b_exp_tx.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
